// File: rtl/cpu_pkg.sv
// Shared definitions for the return-address stack: FSM states and default sizing.
package cpu_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_AW    = 12;

  typedef enum logic {
    NORMAL = 1'b0,
    ERROR  = 1'b1
  } stack_state_e;

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x AW register array, one write port, one
// combinational read port. Contents are not reset; validity is tracked by
// the controller's count.
module ras_mem import cpu_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  // Write port: store the return address at the requested slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: the top entry is visible in the same cycle.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller: circular top pointer, entry count,
// sticky overflow/underflow flags and a NORMAL/ERROR FSM around ras_mem.
module call_stack_ctrl import cpu_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [AW-1:0]            top_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf,
  output logic                     err
);

  localparam int unsigned SPW = $clog2(DEPTH);
  localparam int unsigned CW  = SPW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  stack_state_e   state_q, state_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           set_ovf, set_unf;
  logic           op_en;
  logic           we;
  logic [SPW-1:0] waddr;
  logic [AW-1:0]  rd_data;
  logic           is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  ras_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (sp_q),
    .rdata (rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NORMAL;
    else        state_q <= state_d;
  end

  // FSM next state: any flag being set traps to ERROR; clr_err releases it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: if (set_ovf || set_unf) state_d = ERROR;
      ERROR:  if (clr_err)            state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // FSM outputs: stack operations only run in NORMAL.
  always_comb begin
    err   = (state_q == ERROR);
    op_en = (state_q == NORMAL);
  end

  // Datapath next state. Flush and clr_err both suppress push/pop; flush
  // owns the pointer/count, clr_err owns the flags, so both may act at once.
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    we      = 1'b0;
    waddr   = sp_q + 1'b1;

    if (flush) begin
      sp_d    = '0;
      count_d = '0;
    end

    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (op_en && !flush && !clr_err) begin
      unique case ({push, pop})
        2'b10: begin
          we   = 1'b1;
          sp_d = sp_q + 1'b1;
          if (is_full) set_ovf = 1'b1;
          else         count_d = count_q + 1'b1;
        end
        2'b01: begin
          if (is_empty) begin
            set_unf = 1'b1;
          end else begin
            sp_d    = sp_q - 1'b1;
            count_d = count_q - 1'b1;
          end
        end
        2'b11: begin
          we = 1'b1;
          if (is_empty) begin
            sp_d    = sp_q + 1'b1;
            count_d = count_q + 1'b1;
            set_unf = 1'b1;
          end else begin
            waddr = sp_q;
          end
        end
        default: ;
      endcase
    end

    if (set_ovf) ovf_d = 1'b1;
    if (set_unf) unf_d = 1'b1;
  end

  // Pointer, count and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Status outputs; top reads as zero whenever the stack is empty.
  always_comb begin
    top_addr = is_empty ? '0 : rd_data;
    count    = count_q;
    empty    = is_empty;
    full     = is_full;
    ovf      = ovf_q;
    unf      = unf_q;
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: a DEPTH=8 instance for the main
// sequences and a DEPTH=4 instance for the reset-with-overflow case.
module tb_call_stack_ctrl;

  logic        clk;
  logic        rst_n, push, pop, flush, clr_err;
  logic [11:0] push_addr;
  logic [11:0] top_addr;
  logic [3:0]  count;
  logic        empty, full, ovf, unf, err;

  logic        rst_n4, push4, pop4, flush4, clr_err4;
  logic [11:0] push_addr4;
  logic [11:0] top_addr4;
  logic [2:0]  count4;
  logic        empty4, full4, ovf4, unf4, err4;

  int unsigned vectors;
  int unsigned miscompares;

  call_stack_ctrl #(.DEPTH(8), .AW(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
    .flush(flush), .clr_err(clr_err), .top_addr(top_addr), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .unf(unf), .err(err)
  );

  call_stack_ctrl #(.DEPTH(4), .AW(12)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .push(push4), .pop(pop4), .push_addr(push_addr4),
    .flush(flush4), .clr_err(clr_err4), .top_addr(top_addr4), .count(count4),
    .empty(empty4), .full(full4), .ovf(ovf4), .unf(unf4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [11:0] a);
    push = 1'b1; push_addr = a;
    tick();
    push = 1'b0;
  endtask

  task automatic pop_op();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic clr_op();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; push_addr = '0;
    rst_n4 = 1'b0; push4 = 1'b0; pop4 = 1'b0; flush4 = 1'b0; clr_err4 = 1'b0; push_addr4 = '0;

    // Reset state
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_top",   32'(top_addr), 32'h0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'({ovf, unf}), 32'd0);
    rst_n = 1'b1; rst_n4 = 1'b1;
    tick();

    // Three pushes then three pops, LIFO order
    push_op(12'h010); push_op(12'h020); push_op(12'h030);
    chk("lifo_count3", 32'(count), 32'd3);
    pop = 1'b1;
    chk("lifo_pop1", 32'(top_addr), 32'h030); tick();
    chk("lifo_pop2", 32'(top_addr), 32'h020); tick();
    chk("lifo_pop3", 32'(top_addr), 32'h010); tick();
    pop = 1'b0;
    chk("lifo_empty", 32'(empty), 32'd1);
    chk("lifo_count0", 32'(count), 32'd0);
    chk("lifo_top0", 32'(top_addr), 32'h0);

    // Nine pushes into eight entries: overflow overwrites the oldest
    for (int unsigned i = 1; i <= 9; i++) begin
      push_op(12'(i));
      if (i == 8) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_noovf", 32'(ovf), 32'd0);
        chk("fill_noerr", 32'(err), 32'd0);
      end
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_top", 32'(top_addr), 32'h009);
    clr_op();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    pop = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), 32'(top_addr), 32'(9 - i));
      tick();
    end
    pop = 1'b0;
    chk("ovf_drain_empty", 32'(empty), 32'd1);

    // Pop on empty, then operations ignored in ERROR
    pop = 1'b1;
    chk("unf_top_same_cycle", 32'(top_addr), 32'h0);
    tick();
    pop = 1'b0;
    chk("unf_flag", 32'(unf), 32'd1);
    chk("unf_err", 32'(err), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    push_op(12'h123);
    chk("err_push_ignored", 32'(count), 32'd0);
    chk("err_push_empty", 32'(empty), 32'd1);
    clr_op();
    chk("unf_clr", 32'({err, unf}), 32'd0);

    // Simultaneous push+pop replaces the top
    push_op(12'h033); push_op(12'h044);
    push = 1'b1; pop = 1'b1; push_addr = 12'h055;
    chk("pp_old_top", 32'(top_addr), 32'h044);
    tick();
    push = 1'b0; pop = 1'b0;
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_new_top", 32'(top_addr), 32'h055);
    pop_op();
    chk("pp_below", 32'(top_addr), 32'h033);
    pop_op();

    // Push+pop on empty acts as a push and flags underflow
    push = 1'b1; pop = 1'b1; push_addr = 12'h066;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("ppe_count", 32'(count), 32'd1);
    chk("ppe_top", 32'(top_addr), 32'h066);
    chk("ppe_unf", 32'({unf, err}), 32'b11);
    clr_op();

    // Flush beats a push at count=5
    push_op(12'h071); push_op(12'h072); push_op(12'h073); push_op(12'h074);
    chk("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; push = 1'b1; push_addr = 12'h0FF;
    tick();
    flush = 1'b0; push = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_top", 32'(top_addr), 32'h0);

    // Flush in ERROR clears entries but keeps the sticky flag
    push_op(12'h081);
    pop_op(); pop_op();
    chk("err2_unf", 32'(unf), 32'd1);
    push_op(12'h082);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_keeps_unf", 32'({unf, err}), 32'b11);
    chk("flush_in_err_count", 32'(count), 32'd0);
    clr_op();

    // Asynchronous reset mid-cycle: count=4 on DEPTH=8, count=4 with ovf on DEPTH=4
    push_op(12'h101); push_op(12'h102); push_op(12'h103); push_op(12'h104);
    for (int unsigned i = 1; i <= 5; i++) begin
      push4 = 1'b1; push_addr4 = 12'(12'h200 + i);
      tick();
    end
    push4 = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd4);
    chk("pre_rst_count4", 32'(count4), 32'd4);
    chk("pre_rst_ovf4", 32'({ovf4, err4, full4}), 32'b111);
    chk("pre_rst_top4", 32'(top_addr4), 32'h205);
    #3;
    rst_n = 1'b0; rst_n4 = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_top", 32'(top_addr), 32'h0);
    chk("arst_count4", 32'(count4), 32'd0);
    chk("arst_flags4", 32'({ovf4, unf4, err4, full4}), 32'd0);
    chk("arst_top4", 32'(top_addr4), 32'h0);
    push = 1'b1; push_addr = 12'h3AA;
    tick();
    chk("rst_push_discarded", 32'(count), 32'd0);
    push = 1'b0;
    rst_n = 1'b1; rst_n4 = 1'b1;
    tick();
    chk("post_rst_empty", 32'({empty, full, err}), 32'b100);
    chk("post_rst_top", 32'(top_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning return-address entries (power of two, 2..32).
REQ-002 SHALL have parameter AW, default 12, meaning return-address width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port push  input  1  JSB issued this cycle; push push_addr.
REQ-006 SHALL have port pop  input  1  RET issued this cycle; pop the top entry.
REQ-007 SHALL have port push_addr  input  AW  return address (PC+1) to save.
REQ-008 SHALL have port flush  input  1  discard all entries (pipeline kill/restart).
REQ-009 SHALL have port clr_err  input  1  leave ERROR state and clear sticky flags.
REQ-010 SHALL have port top_addr  output  AW  current top entry, combinational; 0 when empty.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 SHALL have ports empty and full  output  1 each  count==0 and count==DEPTH.
REQ-013 SHALL have ports ovf and unf  output  1 each  sticky overflow and underflow flags.
REQ-014 SHALL have port err  output  1  high while the FSM is in ERROR.

Function
REQ-015 SHALL store entries in a DEPTH x AW register array addressed by a circular top pointer sp of width $clog2(DEPTH).
REQ-016 SHALL, on push only with count<DEPTH, write push_addr at sp+1, advance sp, and increment count, all at the next edge.
REQ-017 SHALL, on push only with count==DEPTH, overwrite the oldest entry (circular wrap), advance sp, keep count at DEPTH, and set ovf.
REQ-018 SHALL, on pop only with count>0, retreat sp and decrement count; popped value is top_addr in the same cycle (zero latency, for PC select).
REQ-019 SHALL, on pop only with count==0, leave sp and count unchanged, drive top_addr 0, and set unf.
REQ-020 SHALL, on push and pop together, overwrite the top entry with push_addr with sp and count unchanged; top_addr shows the old top that cycle; if empty, treat it as push only and set unf.
REQ-021 SHALL give flush priority over push and pop: count and sp go to 0 at the next edge; ovf and unf are unchanged.
REQ-022 SHALL implement FSM states NORMAL and ERROR: NORMAL->ERROR when ovf or unf is being set; ERROR->NORMAL on clr_err; clr_err clears ovf and unf at the same edge.
REQ-023 SHALL, in ERROR, ignore push and pop (no state change) but still honour flush.
REQ-024 SHALL give clr_err priority over a push or pop in the same cycle: the operation is ignored.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force sp=0, count=0, ovf=0, unf=0, and state=NORMAL; array contents need no reset.
REQ-026 SHALL, after reset, output empty=1, full=0, top_addr=0, and err=0; a reset during a push discards that push.

Structure
REQ-027 SHALL place the FSM state enum (NORMAL, ERROR) and the default DEPTH/AW constants in shared package cpu_pkg.
REQ-028 SHALL split the storage array plus write port into the sub-module ras_mem; the pointer, count, and FSM logic stay in call_stack_ctrl.

Verification
REQ-029 SHALL cover: push 0x010, 0x020, 0x030, then 3 pops -> top_addr 0x030, 0x020, 0x010; then empty=1, count=0.
REQ-030 SHALL cover: 9 pushes of 0x001..0x009 with DEPTH=8 -> full=1, ovf=1, err=1; after clr_err, 8 pops return 0x009..0x002.
REQ-031 SHALL cover: pop on empty -> top_addr=0, unf=1, err=1; a push during ERROR is ignored (count stays 0).
REQ-032 SHALL cover: with count=2 and top 0x044, push 0x055 and pop together -> count=2, top_addr 0x044 that cycle and 0x055 next cycle.
REQ-033 SHALL cover: flush asserted with push at count=5 -> count=0, empty=1 next cycle.
REQ-034 SHALL cover: rst_n pulsed low mid-cycle with count=4 and ovf=1 -> outputs reset immediately without a clock edge.
